// File: rtl/oled_text_buffer.sv
// oled_text_buffer: 4x16 character frame buffer for an OLED text display.
// Game logic writes single characters, or 0..999 numbers rendered as three
// decimal digits. A snapshot copy of the buffer drives row0..row3 so the
// OLED interface always sees a consistent frame while it redraws.
module oled_text_buffer #(
  parameter logic [7:0] RESET_CHAR   = 8'h20,
  parameter bit         AUTO_REFRESH = 1'b1,
  parameter bit         LEADING_ZERO = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         wr_num,
  input  logic [1:0]   wr_row,
  input  logic [3:0]   wr_col,
  input  logic [9:0]   wr_data,
  output logic         wr_ready,
  input  logic         refresh_req,
  output logic [0:127] row0,
  output logic [0:127] row1,
  output logic [0:127] row2,
  output logic [0:127] row3,
  output logic         oled_enable,
  input  logic         oled_done,
  output logic         busy
);

  typedef enum logic [1:0] {W_IDLE, W_HUND, W_TENS, W_COMMIT} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DRAIN} rf_state_t;

  wr_state_t  wr_state_reg, wr_state_next;
  rf_state_t  rf_state_reg, rf_state_next;

  logic [7:0] text_reg [0:63];
  logic [7:0] snap_reg [0:63];

  logic [1:0] num_row_reg;
  logic [3:0] num_col_reg;
  logic [9:0] rem_reg;
  logic [3:0] hund_reg;
  logic [3:0] tens_reg;
  logic       dirty_reg;
  logic       pend_reg;

  logic       char_acc, num_acc, commit, start, hund_step, tens_step;
  logic [7:0] hund_chr, tens_chr, unit_chr;
  logic [4:0] col1, col2;

  assign wr_ready  = (wr_state_reg == W_IDLE);
  assign char_acc  = wr_en && wr_ready && !wr_num;
  assign num_acc   = wr_en && wr_ready && wr_num;
  assign commit    = (wr_state_reg == W_COMMIT);
  assign hund_step = (wr_state_reg == W_HUND) && (rem_reg >= 10'd100);
  assign tens_step = (wr_state_reg == W_TENS) && (rem_reg >= 10'd10);

  // Digit glyphs; suppressed leading zeros become spaces, units always shown.
  assign hund_chr = (!LEADING_ZERO && hund_reg == 4'd0) ? 8'h20 : (8'h30 + {4'd0, hund_reg});
  assign tens_chr = (!LEADING_ZERO && hund_reg == 4'd0 && tens_reg == 4'd0) ? 8'h20
                                                                           : (8'h30 + {4'd0, tens_reg});
  assign unit_chr = 8'h30 + {4'd0, rem_reg[3:0]};

  // Bit 4 set means the digit falls off the right edge and is dropped.
  assign col1 = {1'b0, num_col_reg} + 5'd1;
  assign col2 = {1'b0, num_col_reg} + 5'd2;

  assign start = (rf_state_reg == R_IDLE) &&
                 ((AUTO_REFRESH && dirty_reg) || refresh_req || pend_reg);

  assign oled_enable = (rf_state_reg == R_START);
  assign busy        = (rf_state_reg != R_IDLE);

  // Conversion and refresh state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_reg <= W_IDLE;
      rf_state_reg <= R_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rf_state_reg <= rf_state_next;
    end
  end

  // Number conversion sequencing: subtract hundreds, then tens, then commit.
  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:   if (num_acc) wr_state_next = W_HUND;
      W_HUND:   if (rem_reg < 10'd100) wr_state_next = W_TENS;
      W_TENS:   if (rem_reg < 10'd10) wr_state_next = W_COMMIT;
      W_COMMIT: wr_state_next = W_IDLE;
      default:  wr_state_next = W_IDLE;
    endcase
  end

  // Refresh handshake: raise enable until done, then wait for done to drop.
  always_comb begin
    rf_state_next = rf_state_reg;
    case (rf_state_reg)
      R_IDLE:  if (start) rf_state_next = R_START;
      R_START: if (oled_done) rf_state_next = R_DRAIN;
      R_DRAIN: if (!oled_done) rf_state_next = R_IDLE;
      default: rf_state_next = R_IDLE;
    endcase
  end

  // Conversion datapath: latch target, clamp value, count digits by subtraction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_row_reg <= 2'd0;
      num_col_reg <= 4'd0;
      rem_reg     <= 10'd0;
      hund_reg    <= 4'd0;
      tens_reg    <= 4'd0;
    end else if (num_acc) begin
      num_row_reg <= wr_row;
      num_col_reg <= wr_col;
      rem_reg     <= (wr_data > 10'd999) ? 10'd999 : wr_data;
      hund_reg    <= 4'd0;
      tens_reg    <= 4'd0;
    end else if (hund_step) begin
      rem_reg  <= rem_reg - 10'd100;
      hund_reg <= hund_reg + 4'd1;
    end else if (tens_step) begin
      rem_reg  <= rem_reg - 10'd10;
      tens_reg <= tens_reg + 4'd1;
    end
  end

  // Text buffer: single character writes and committed number digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) text_reg[i] <= RESET_CHAR;
    end else begin
      if (char_acc) text_reg[{wr_row, wr_col}] <= wr_data[7:0];
      if (commit) begin
        text_reg[{num_row_reg, num_col_reg}] <= hund_chr;
        if (!col1[4]) text_reg[{num_row_reg, col1[3:0]}] <= tens_chr;
        if (!col2[4]) text_reg[{num_row_reg, col2[3:0]}] <= unit_chr;
      end
    end
  end

  // Snapshot: whole-buffer copy only on the edge that starts a refresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) snap_reg[i] <= RESET_CHAR;
    end else if (start) begin
      for (int i = 0; i < 64; i++) snap_reg[i] <= text_reg[i];
    end
  end

  // Dirty and pending flags; a write in the start cycle keeps dirty set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_reg <= 1'b1;
      pend_reg  <= 1'b0;
    end else begin
      dirty_reg <= (dirty_reg && !start) || char_acc || commit;
      if (start) pend_reg <= 1'b0;
      else if (refresh_req && busy) pend_reg <= 1'b1;
    end
  end

  // Row outputs: column c of each row sits at bits [8c:8c+7], MSB first.
  for (genvar gi = 0; gi < 16; gi++) begin : g_col
    assign row0[8*gi +: 8] = snap_reg[gi];
    assign row1[8*gi +: 8] = snap_reg[16 + gi];
    assign row2[8*gi +: 8] = snap_reg[32 + gi];
    assign row3[8*gi +: 8] = snap_reg[48 + gi];
  end

endmodule

// File: tb/tb_oled_text_buffer.sv
// Testbench for oled_text_buffer: directed scenarios plus a random phase,
// checked every cycle against a behavioural model of buffer, snapshot and
// refresh handshake.
module tb_oled_text_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic         wr_num;
  logic [1:0]   wr_row;
  logic [3:0]   wr_col;
  logic [9:0]   wr_data;
  logic         wr_ready;
  logic         refresh_req;
  logic [0:127] row0, row1, row2, row3;
  logic         oled_enable;
  logic         oled_done;
  logic         busy;

  always #5 clk = ~clk;

  oled_text_buffer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_num(wr_num),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ready(wr_ready),
    .refresh_req(refresh_req), .row0(row0), .row1(row1), .row2(row2), .row3(row3),
    .oled_enable(oled_enable), .oled_done(oled_done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_buf  [64];
  logic [7:0] m_snap [64];
  logic [7:0] m_dig  [3];
  logic       m_dirty, m_pend;
  int         m_phase;          // 0 idle, 1 enable high, 2 waiting for done low
  int         m_cd;             // edges until the pending number commits
  int         m_nrow, m_ncol;

  // OLED responder and observation state
  int   done_delay = 5;
  int   en_cnt = 0, lo_cnt = 0;
  int   dut_starts = 0;
  logic prev_en = 1'b0;
  int   s0, lows;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_rows();
    logic [511:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        v[511 - 128*r - 8*c -: 8] = m_snap[16*r + c];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_buf[i]  = 8'h20;
      m_snap[i] = 8'h20;
    end
    m_dirty = 1'b1;
    m_pend  = 1'b0;
    m_phase = 0;
    m_cd    = 0;
  endtask

  task automatic m_put(input int row, input int col, input logic [7:0] ch);
    if (col < 16) m_buf[16*row + col] = ch;
  endtask

  // One clock cycle: model the edge, sample DUT 1 time unit later, respond.
  task automatic step();
    bit ready_pre, char_acc, num_acc, commit_now, wr_evt;
    int v, h, t, u;
    ready_pre  = (m_cd == 0);
    commit_now = 1'b0;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      char_acc = wr_en && !wr_num && ready_pre;
      num_acc  = wr_en && wr_num && ready_pre;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) commit_now = 1'b1;
      end
      wr_evt = char_acc || commit_now;
      case (m_phase)
        0: if (m_dirty || refresh_req || m_pend) begin
             m_snap  = m_buf;
             m_dirty = 1'b0;
             m_pend  = 1'b0;
             m_phase = 1;
           end
        1: begin
             if (refresh_req) m_pend = 1'b1;
             if (oled_done) m_phase = 2;
           end
        default: begin
             if (refresh_req) m_pend = 1'b1;
             if (!oled_done) m_phase = 0;
           end
      endcase
      if (wr_evt) m_dirty = 1'b1;
      if (char_acc) m_put(int'(wr_row), int'(wr_col), wr_data[7:0]);
      if (commit_now) begin
        m_put(m_nrow, m_ncol, m_dig[0]);
        m_put(m_nrow, m_ncol + 1, m_dig[1]);
        m_put(m_nrow, m_ncol + 2, m_dig[2]);
      end
      if (num_acc) begin
        v = (int'(wr_data) > 999) ? 999 : int'(wr_data);
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        m_dig[0] = (h == 0) ? 8'h20 : 8'(8'h30 + h);
        m_dig[1] = (h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t);
        m_dig[2] = 8'(8'h30 + u);
        m_nrow = int'(wr_row);
        m_ncol = int'(wr_col);
        m_cd   = h + t + 3;
      end
    end
    #1;
    check("wr_ready", 32'(wr_ready), 32'(m_cd == 0));
    check("oled_enable", 32'(oled_enable), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check_rows("rows", {row0, row1, row2, row3}, exp_rows());
    if (oled_enable && !prev_en) dut_starts++;
    prev_en = oled_enable;
    if (oled_enable) begin
      en_cnt++;
      lo_cnt = 0;
      if (en_cnt >= done_delay) oled_done = 1'b1;
    end else begin
      en_cnt = 0;
      if (oled_done) begin
        lo_cnt++;
        if (lo_cnt >= 2) begin
          oled_done = 1'b0;
          lo_cnt = 0;
        end
      end
    end
    wr_en = 1'b0;
    refresh_req = 1'b0;
  endtask

  // Run until model is fully idle; an expired budget is a failure.
  task automatic settle(input int max, input string tag);
    int n;
    n = 0;
    while ((m_phase != 0 || m_dirty || m_pend || m_cd != 0 || oled_done) && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(n < max), 32'd1);
  endtask

  task automatic put_char(input int row, input int col, input logic [7:0] ch);
    wr_en = 1'b1; wr_num = 1'b0;
    wr_row = 2'(row); wr_col = 4'(col); wr_data = {2'b00, ch};
    step();
  endtask

  initial begin
    wr_en = 1'b0; wr_num = 1'b0; wr_row = 2'd0; wr_col = 4'd0; wr_data = 10'd0;
    refresh_req = 1'b0; oled_done = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_enable", 32'(oled_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_rows("rst_rows", {row0, row1, row2, row3}, exp_rows());
    reset = 1'b0;

    // Boot refresh starts on the first edge after reset release
    step();
    check("boot_enable", 32'(oled_enable), 32'd1);
    settle(40, "boot_settle");
    check("boot_refreshes", 32'(dut_starts), 32'd1);

    // Char write into the last column of row 2
    s0 = dut_starts;
    put_char(2, 15, 8'h4D);
    settle(40, "char_settle");
    check("char_refreshes", 32'(dut_starts - s0), 32'd1);
    check("row2_col15", 32'(row2[120:127]), 32'h4D);

    // 1023 clamps to 999; conversion holds wr_ready low 21 cycles
    wr_en = 1'b1; wr_num = 1'b1; wr_row = 2'd0; wr_col = 4'd0; wr_data = 10'd1023;
    step();
    lows = 0;
    while (wr_ready === 1'b0 && lows < 40) begin
      lows++;
      step();
    end
    check("num999_ready_low", 32'(lows), 32'd21);
    settle(40, "num999_settle");
    check("row0_999", 32'(row0[0:23]), 32'h393939);

    // 7 at column 14: two blanks, units digit falls off the row
    put_char(1, 14, 8'h41);
    put_char(1, 15, 8'h41);
    wr_en = 1'b1; wr_num = 1'b1; wr_row = 2'd1; wr_col = 4'd14; wr_data = 10'd7;
    step();
    settle(60, "num7_settle");
    check("row1_col14_15", 32'(row1[112:127]), 32'h2020);

    // Char write coinciding with a refresh start
    s0 = dut_starts;
    wr_en = 1'b1; wr_num = 1'b0; wr_row = 2'd3; wr_col = 4'd0; wr_data = 10'h05A;
    refresh_req = 1'b1;
    step();
    check("coincident_excluded", 32'(row3[0:7]), 32'h20);
    settle(60, "coincident_settle");
    check("coincident_refreshes", 32'(dut_starts - s0), 32'd2);
    check("coincident_later", 32'(row3[0:7]), 32'h5A);

    // Three requests during one busy refresh collapse into one extra
    s0 = dut_starts;
    refresh_req = 1'b1;
    step();
    step();
    refresh_req = 1'b1;
    step();
    step();
    refresh_req = 1'b1;
    step();
    refresh_req = 1'b1;
    step();
    settle(60, "pend_settle");
    check("pend_refreshes", 32'(dut_starts - s0), 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) done_delay = int'($urandom_range(1, 6));
      if ($urandom_range(0, 99) < 30) begin
        wr_en   = 1'b1;
        wr_num  = 1'($urandom_range(0, 1));
        wr_row  = 2'($urandom_range(0, 3));
        wr_col  = 4'($urandom_range(0, 15));
        wr_data = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 99) < 5) refresh_req = 1'b1;
      step();
    end
    done_delay = 5;
    settle(80, "random_settle");

    // Async reset mid-conversion (tens phase) with a refresh held in R_START
    done_delay = 40;
    wr_en = 1'b1; wr_num = 1'b1; wr_row = 2'd0; wr_col = 4'd3; wr_data = 10'd999;
    refresh_req = 1'b1;
    step();
    repeat (13) step();
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_ready", 32'(wr_ready), 32'd1);
    check("async_enable", 32'(oled_enable), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    model_reset();
    oled_done = 1'b0; en_cnt = 0; lo_cnt = 0; prev_en = 1'b0;
    check_rows("async_rows", {row0, row1, row2, row3}, exp_rows());
    step();
    step();
    reset = 1'b0;
    done_delay = 5;
    settle(80, "post_reset_settle");
    check("post_reset_row0", 32'(row0[24:47]), 32'h202020);
    check("post_reset_row2", 32'(row2[120:127]), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
